// File: rtl/train_pulse_seq_if.sv
// Handshake/state bundle between the training controller and the pulse sequencer.
// The slave modport is the sequencer side; the master modport is the controller/bench side.
interface train_pulse_seq_if;
    logic [2:0] system_state;
    logic       key_state;
    logic       start;
    logic [3:0] dac_top_state;
    logic [1:0] pulse17_state;
    logic [1:0] pulse27_state;
    logic       busy;
    logic       done;

    modport master (
        output system_state, key_state, start,
        input  dac_top_state, pulse17_state, pulse27_state, busy, done
    );

    modport slave (
        input  system_state, key_state, start,
        output dac_top_state, pulse17_state, pulse27_state, busy, done
    );
endinterface

// File: rtl/train_pulse_seq.sv
// Training-phase pulse sequencer driving the shared state buses of all switch drivers.
// Optional macro TRAIN_PULSE_REPEAT_EN repeats the programming chain N_REPEAT times before the read window.
module train_pulse_seq #(
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned ACTIVE_CYC  = 4,
    parameter int unsigned RELEASE_CYC = 2,
    parameter int unsigned CNT1_CYC    = 3,
    parameter int unsigned V2_CYC      = 5,
    parameter int unsigned CNT2_CYC    = 3,
    parameter int unsigned READ_CYC    = 4,
    parameter int unsigned CW          = 16
`ifdef TRAIN_PULSE_REPEAT_EN
    , parameter int unsigned N_REPEAT  = 2
`endif
) (
    input logic               clk,
    input logic               rst_n,
    train_pulse_seq_if.slave  bus
);
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_V1_2     = 4'd1;
    localparam logic [3:0] S_CNT_1_2  = 4'd2;
    localparam logic [3:0] S_V2_2     = 4'd3;
    localparam logic [3:0] S_CNT_2_2  = 4'd4;
    localparam logic [3:0] S_V_READ   = 4'd5;
    localparam logic [3:0] S_COMPLETE = 4'd6;
    localparam logic [3:0] S_V1_1     = 4'd7;
    localparam logic [3:0] S_V2_1     = 4'd8;
    localparam logic [3:0] S_CNT_1_1  = 4'd9;
    localparam logic [3:0] S_CNT_2_1  = 4'd10;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [3:0]    state_r, next_state_s;
    logic [1:0]    phase_r, next_phase_s;
    logic [CW-1:0] cnt_r, next_cnt_s;
    logic [1:0]    pulse17_r, pulse27_r;
    logic          busy_r, done_r;
    logic          en_s, hit_s, rep_last_s;
    logic [3:0]    succ_s;
`ifdef TRAIN_PULSE_REPEAT_EN
    logic [CW-1:0] rep_r, next_rep_s;
`endif

    // Last count value of the current dwell; pulse states dwell per phase.
    function automatic logic [CW-1:0] dwell_last(input logic [3:0] st, input logic [1:0] ph);
        logic [CW-1:0] r;
        case (st)
            S_V1_1, S_V1_2: begin
                case (ph)
                    2'd1:    r = CW'(SETUP_CYC - 32'd1);
                    2'd2:    r = CW'(ACTIVE_CYC - 32'd1);
                    2'd3:    r = CW'(RELEASE_CYC - 32'd1);
                    default: r = CNT_ZERO;
                endcase
            end
            S_CNT_1_1, S_CNT_1_2: r = CW'(CNT1_CYC - 32'd1);
            S_V2_1, S_V2_2:       r = CW'(V2_CYC - 32'd1);
            S_CNT_2_1, S_CNT_2_2: r = CW'(CNT2_CYC - 32'd1);
            S_V_READ:             r = CW'(READ_CYC - 32'd1);
            default:              r = CNT_ZERO;
        endcase
        return r;
    endfunction

    // Fixed successor of each timed state in the chain.
    function automatic logic [3:0] succ_of(input logic [3:0] st, input logic last);
        logic [3:0] r;
        case (st)
            S_V1_1:    r = S_CNT_1_1;
            S_CNT_1_1: r = S_V2_1;
            S_V2_1:    r = S_CNT_2_1;
            S_CNT_2_1: r = S_V1_2;
            S_V1_2:    r = S_CNT_1_2;
            S_CNT_1_2: r = S_V2_2;
            S_V2_2:    r = S_CNT_2_2;
            S_CNT_2_2: r = last ? S_V_READ : S_V1_1;
            S_V_READ:  r = S_COMPLETE;
            default:   r = S_IDLE;
        endcase
        return r;
    endfunction

`ifdef TRAIN_PULSE_REPEAT_EN
    assign rep_last_s = (rep_r == CW'(N_REPEAT - 32'd1));
`else
    assign rep_last_s = 1'b1;
`endif

    // Next-state, phase and dwell-counter logic; abort outranks every advance.
    always_comb begin
        en_s         = bus.key_state && (bus.system_state == 3'd2);
        hit_s        = (cnt_r == dwell_last(state_r, phase_r));
        succ_s       = succ_of(state_r, rep_last_s);
        next_state_s = state_r;
        next_phase_s = phase_r;
        next_cnt_s   = cnt_r + CNT_ONE;
`ifdef TRAIN_PULSE_REPEAT_EN
        next_rep_s   = rep_r;
`endif
        if ((state_r != S_IDLE) && !en_s) begin
            next_state_s = S_IDLE;
            next_phase_s = 2'd0;
            next_cnt_s   = CNT_ZERO;
`ifdef TRAIN_PULSE_REPEAT_EN
            next_rep_s   = CNT_ZERO;
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    next_cnt_s = CNT_ZERO;
`ifdef TRAIN_PULSE_REPEAT_EN
                    next_rep_s = CNT_ZERO;
`endif
                    if (bus.start && en_s) begin
                        next_state_s = S_V1_1;
                        next_phase_s = 2'd1;
                    end else begin
                        next_state_s = S_IDLE;
                        next_phase_s = 2'd0;
                    end
                end
                S_V1_1, S_V1_2: begin
                    if (hit_s) begin
                        next_cnt_s = CNT_ZERO;
                        if (phase_r == 2'd3) begin
                            next_state_s = succ_s;
                            next_phase_s = 2'd0;
                        end else begin
                            next_phase_s = phase_r + 2'd1;
                        end
                    end else begin
                        next_phase_s = phase_r;
                    end
                end
                S_CNT_1_1, S_V2_1, S_CNT_2_1, S_CNT_1_2, S_V2_2, S_CNT_2_2, S_V_READ: begin
                    if (hit_s) begin
                        next_cnt_s   = CNT_ZERO;
                        next_state_s = succ_s;
                        next_phase_s = ((succ_s == S_V1_1) || (succ_s == S_V1_2)) ? 2'd1 : 2'd0;
`ifdef TRAIN_PULSE_REPEAT_EN
                        if ((state_r == S_CNT_2_2) && !rep_last_s) begin
                            next_rep_s = rep_r + CNT_ONE;
                        end else begin
                            next_rep_s = rep_r;
                        end
`endif
                    end else begin
                        next_state_s = state_r;
                    end
                end
                default: begin
                    // COMPLETE and the unused codes both fall back to IDLE.
                    next_state_s = S_IDLE;
                    next_phase_s = 2'd0;
                    next_cnt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // State and output registers; outputs are derived from next-state values so they align with state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            phase_r   <= 2'd0;
            cnt_r     <= CNT_ZERO;
            pulse17_r <= 2'd0;
            pulse27_r <= 2'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
`ifdef TRAIN_PULSE_REPEAT_EN
            rep_r     <= CNT_ZERO;
`endif
        end else begin
            state_r   <= next_state_s;
            phase_r   <= next_phase_s;
            cnt_r     <= next_cnt_s;
            pulse17_r <= (next_state_s == S_V1_1) ? next_phase_s : 2'd0;
            pulse27_r <= (next_state_s == S_V1_2) ? next_phase_s : 2'd0;
            busy_r    <= (next_state_s != S_IDLE);
            done_r    <= (next_state_s == S_COMPLETE);
`ifdef TRAIN_PULSE_REPEAT_EN
            rep_r     <= next_rep_s;
`endif
        end
    end

    assign bus.dac_top_state = state_r;
    assign bus.pulse17_state = pulse17_r;
    assign bus.pulse27_state = pulse27_r;
    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
endmodule

// File: doc/train_pulse_seq.md
Name: train_pulse_seq

Overview:
Training-phase pulse sequencer. It generates the dac_top_state and pulse17_state/pulse27_state codes consumed by the per-switch drivers (in-line switch control blocks).
- On a start request during training mode it walks two programming half-cycles, then a read window, then completion.
- It sits beside the DAC top controller. It is the single source of the state buses fanned out to all switch drivers.

Parameters:
SETUP_CYC, 2, cycles pulse code = 1 (setup) per pulse phase; min 1
ACTIVE_CYC, 4, cycles pulse code = 2 (active) per pulse phase; min 1
RELEASE_CYC, 2, cycles pulse code = 3 (release) per pulse phase; min 1
CNT1_CYC, 3, dwell cycles in CNT_1_x; min 1
V2_CYC, 5, dwell cycles in V2_x; min 1
CNT2_CYC, 3, dwell cycles in CNT_2_x; min 1
READ_CYC, 4, dwell cycles in V_READ; min 1
CW, 16, internal dwell counter width; all *_CYC must be < 2^CW

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
system_state  in  3  top mode; 3'd2 = training, others inhibit sequencing
key_state  in  1  global enable; low forces abort
start  in  1  single-cycle request to run one sequence
dac_top_state  out  4  sequencer state code (encoding below)
pulse17_state  out  2  phase code for half-cycle 1 pulse: 0 none, 1 setup, 2 active, 3 release
pulse27_state  out  2  phase code for half-cycle 2 pulse, same encoding
busy  out  1  high whenever dac_top_state != IDLE
done  out  1  one-cycle pulse while in COMPLETE

Behaviour:
- State encoding is fixed to match the switch drivers:
  - IDLE=0, V1_2=1, CNT_1_2=2, V2_2=3, CNT_2_2=4, V_READ=5, COMPLETE=6
  - V1_1=7, V2_1=8, CNT_1_1=9, CNT_2_1=10
  - Codes 11-15 are unused; if reached, the next state is IDLE.
- Reset (rst_n low at clk edge):
  - dac_top_state=IDLE, pulse17_state=0, pulse27_state=0, busy=0, done=0
  - Dwell and phase counters cleared.
- All outputs are registered.
- Enable condition: en = key_state && (system_state==3'd2).
- IDLE -> V1_1 when start && en. Start is sampled at cycle t; dac_top_state=V1_1 and pulse17_state=1 from t+1. Start is ignored when not IDLE or when en=0.
- V1_1 pulse sub-sequence:
  - pulse17_state = 1 for SETUP_CYC cycles, then 2 for ACTIVE_CYC, then 3 for RELEASE_CYC.
  - Then pulse17_state=0 and the state moves to CNT_1_1.
  - pulse27_state=0 throughout.
- Fixed dwell chain: CNT_1_1 (CNT1_CYC) -> V2_1 (V2_CYC) -> CNT_2_1 (CNT2_CYC) -> V1_2.
- V1_2 runs the same pulse sub-sequence on pulse27_state (pulse17_state=0), then continues:
  - CNT_1_2 (CNT1_CYC) -> V2_2 (V2_CYC) -> CNT_2_2 (CNT2_CYC) -> V_READ (READ_CYC) -> COMPLETE (1 cycle, done=1) -> IDLE.
- Pulse codes are 0 in every state other than V1_1 / V1_2.
- Dwell counter:
  - Loaded to 0 on state entry.
  - State exits when count == N-1.
  - No wrap: the counter is cleared on every transition.
- Abort: if en==0 on any cycle while busy, the next cycle has dac_top_state=IDLE, both pulse codes 0, done=0. A COMPLETE cycle interrupted this way does not emit done.
- Simultaneous events:
  - Abort has priority over normal advance.
  - start during COMPLETE is ignored; a new run needs start while in IDLE.
- Reset mid-operation behaves identically to abort but takes precedence over everything.
- With defaults, a full run is 43 busy cycles: t+1..t+43, done at t+43, IDLE at t+44.

Optional Feature:
- Macro: TRAIN_PULSE_REPEAT_EN.
- When defined:
  - Adds parameter N_REPEAT (default 2, min 1) and a repeat counter.
  - The chain V1_1..CNT_2_1..V1_2..CNT_2_2 executes N_REPEAT times before V_READ. CNT_2_2 -> V1_1 until the last iteration.
  - Abort clears the repeat counter.
- When undefined: a single pass, exactly as described above. No extra parameter or logic.

Test Plan:
- Reset, then idle with en=1, no start -> dac_top_state=0, pulse codes 0, busy=0 for 20 cycles.
- Defaults, en=1, start at cycle t:
  - dac_top_state: 7 at t+1..t+8, 9 at t+9..t+11, 8 at t+12..t+16, 10 at t+17..t+19, 1 at t+20..t+27, 2 at t+28..t+30, 3 at t+31..t+35, 4 at t+36..t+38, 5 at t+39..t+42, 6 at t+43, 0 at t+44.
  - done high only at t+43.
- Pulse phase check in the same run:
  - pulse17_state = 1 at t+1..t+2, 2 at t+3..t+6, 3 at t+7..t+8, 0 otherwise.
  - pulse27_state = 1 at t+20..t+21, 2 at t+22..t+25, 3 at t+26..t+27.
- Drop key_state at t+10 (in CNT_1_1) -> IDLE and pulse codes 0 at t+11. No done. A start at t+15 with en=1 restarts at V1_1 at t+16.
- system_state=3'd1 with start pulse -> remains IDLE. Start at t+5 during a run -> ignored, sequence timing unchanged.
- TRAIN_PULSE_REPEAT_EN, N_REPEAT=2, defaults, start at t -> V_READ entered at t+77, done at t+81.
